// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants
// Hazard FSM encoding, default bundle widths and the hard-wired zero register.
package pipe_pkg;
   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_e;

   localparam int         CTRL_W_DEF = 16;
   localparam int         CNT_W_DEF  = 32;
   localparam logic [4:0] X0         = 5'd0;
endpackage

// File: rtl/id_ex_hazard_seg_if.sv
// rtl/id_ex_hazard_seg_if.sv - ID/EX segment and hazard control bus
// master drives the ID-side fields and EX feedback; slave is the segment register.
interface id_ex_hazard_seg_if #(
   parameter int CTRL_W = pipe_pkg::CTRL_W_DEF,
   parameter int CNT_W  = pipe_pkg::CNT_W_DEF
);
   logic              id_valid;
   logic [4:0]        id_ra0;
   logic [4:0]        id_ra1;
   logic [31:0]       id_rd0;
   logic [31:0]       id_rd1;
   logic [4:0]        id_wa;
   logic              id_we;
   logic              id_is_load;
   logic              id_is_md;
   logic [CTRL_W-1:0] id_ctrl;
   logic              ex_br_taken;
   logic              md_done;

   logic              ex_valid;
   logic [4:0]        rf_ra0_ex;
   logic [4:0]        rf_ra1_ex;
   logic [31:0]       rf_rd0_ex;
   logic [31:0]       rf_rd1_ex;
   logic [4:0]        rf_wa_ex;
   logic              rf_we_ex;
   logic [CTRL_W-1:0] ctrl_ex;
   logic              md_start;
   logic              stall_pc;
   logic              stall_if_id;
   logic              flush_if_id;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_ra0, id_ra1, id_rd0, id_rd1, id_wa, id_we,
             id_is_load, id_is_md, id_ctrl, ex_br_taken, md_done,
      input  ex_valid, rf_ra0_ex, rf_ra1_ex, rf_rd0_ex, rf_rd1_ex, rf_wa_ex,
             rf_we_ex, ctrl_ex, md_start, stall_pc, stall_if_id, flush_if_id,
             stall_cnt
   );

   modport slave (
      input  id_valid, id_ra0, id_ra1, id_rd0, id_rd1, id_wa, id_we,
             id_is_load, id_is_md, id_ctrl, ex_br_taken, md_done,
      output ex_valid, rf_ra0_ex, rf_ra1_ex, rf_rd0_ex, rf_rd1_ex, rf_wa_ex,
             rf_we_ex, ctrl_ex, md_start, stall_pc, stall_if_id, flush_if_id,
             stall_cnt
   );
endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational hazard terms
// Load-use, taken-branch flush and multi-cycle occupancy from EX state and ID operands.
module hazard_detect import pipe_pkg::*; (
   input  logic       id_valid,
   input  logic [4:0] id_ra0,
   input  logic [4:0] id_ra1,
   input  logic       ex_valid,
   input  logic       ex_is_load,
   input  logic       ex_is_md,
   input  logic       ex_we,
   input  logic [4:0] ex_wa,
   input  logic       ex_br_taken,
   input  logic       md_wait,
   input  logic       md_done,
   output logic       load_use,
   output logic       br_flush,
   output logic       md_hold
);
   // The md op releases EX in the same cycle its result arrives.
   assign md_hold  = ex_valid & ex_is_md & ~(md_wait & md_done);
   assign load_use = id_valid & ex_valid & ex_is_load & ex_we & (ex_wa != X0)
                   & ((ex_wa == id_ra0) | (ex_wa == id_ra1));
   assign br_flush = ex_valid & ex_br_taken & ~md_hold;
endmodule

// File: rtl/id_ex_hazard_seg.sv
// rtl/id_ex_hazard_seg.sv - ID/EX segment register with hazard controller
// Holds, bubbles or loads the EX stage and drives PC/IF-ID stall and flush.
module id_ex_hazard_seg import pipe_pkg::*; #(
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input logic               clk,
   input logic               rst,
   id_ex_hazard_seg_if.slave bus
);
   state_e            state_q, state_d;
   logic              ex_valid_q, ex_valid_d;
   logic [4:0]        ra0_q, ra0_d;
   logic [4:0]        ra1_q, ra1_d;
   logic [31:0]       rd0_q, rd0_d;
   logic [31:0]       rd1_q, rd1_d;
   logic [4:0]        wa_q, wa_d;
   logic              we_q, we_d;
   logic              is_load_q, is_load_d;
   logic              is_md_q, is_md_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic load_use, br_flush, md_hold, md_wait, stall;

   assign md_wait = (state_q == MD_WAIT);

   hazard_detect u_hazard_detect (
      .id_valid    (bus.id_valid),
      .id_ra0      (bus.id_ra0),
      .id_ra1      (bus.id_ra1),
      .ex_valid    (ex_valid_q),
      .ex_is_load  (is_load_q),
      .ex_is_md    (is_md_q),
      .ex_we       (we_q),
      .ex_wa       (wa_q),
      .ex_br_taken (bus.ex_br_taken),
      .md_wait     (md_wait),
      .md_done     (bus.md_done),
      .load_use    (load_use),
      .br_flush    (br_flush),
      .md_hold     (md_hold)
   );

   // A taken branch kills the wrong-path ID instr, so it outranks load-use.
   assign stall = md_hold | (load_use & ~br_flush);

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (ex_valid_q && is_md_q) state_d = MD_WAIT;
         MD_WAIT: if (bus.md_done) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      ex_valid_d = ex_valid_q;
      ra0_d      = ra0_q;
      ra1_d      = ra1_q;
      rd0_d      = rd0_q;
      rd1_d      = rd1_q;
      wa_d       = wa_q;
      we_d       = we_q;
      is_load_d  = is_load_q;
      is_md_d    = is_md_q;
      ctrl_d     = ctrl_q;
      if (!md_hold) begin
         if (br_flush || load_use) begin
            ex_valid_d = 1'b0;
            we_d       = 1'b0;
            is_load_d  = 1'b0;
            is_md_d    = 1'b0;
         end else begin
            ex_valid_d = bus.id_valid;
            ra0_d      = bus.id_ra0;
            ra1_d      = bus.id_ra1;
            rd0_d      = bus.id_rd0;
            rd1_d      = bus.id_rd1;
            wa_d       = bus.id_wa;
            we_d       = bus.id_we;
            is_load_d  = bus.id_is_load;
            is_md_d    = bus.id_is_md;
            ctrl_d     = bus.id_ctrl;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         ex_valid_q <= 1'b0;
         ra0_q      <= '0;
         ra1_q      <= '0;
         rd0_q      <= '0;
         rd1_q      <= '0;
         wa_q       <= '0;
         we_q       <= 1'b0;
         is_load_q  <= 1'b0;
         is_md_q    <= 1'b0;
         ctrl_q     <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ex_valid_q <= ex_valid_d;
         ra0_q      <= ra0_d;
         ra1_q      <= ra1_d;
         rd0_q      <= rd0_d;
         rd1_q      <= rd1_d;
         wa_q       <= wa_d;
         we_q       <= we_d;
         is_load_q  <= is_load_d;
         is_md_q    <= is_md_d;
         ctrl_q     <= ctrl_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.ex_valid    = ex_valid_q;
   assign bus.rf_ra0_ex   = ra0_q;
   assign bus.rf_ra1_ex   = ra1_q;
   assign bus.rf_rd0_ex   = rd0_q;
   assign bus.rf_rd1_ex   = rd1_q;
   assign bus.rf_wa_ex    = wa_q;
   assign bus.rf_we_ex    = ex_valid_q & we_q;
   assign bus.ctrl_ex     = ctrl_q;
   assign bus.md_start    = (state_q == RUN) & ex_valid_q & is_md_q;
   assign bus.stall_pc    = stall;
   assign bus.stall_if_id = stall;
   assign bus.flush_if_id = br_flush & ~md_hold;
   assign bus.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_id_ex_hazard_seg.sv
// tb/tb_id_ex_hazard_seg.sv - self-checking bench for id_ex_hazard_seg
// Directed hazard scenarios followed by random traffic against an instruction-level model.
module tb_id_ex_hazard_seg;
   localparam int CTRL_W = 16;
   localparam int CNT_W  = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   id_ex_hazard_seg_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

   id_ex_hazard_seg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic              valid;
      logic [4:0]        ra0, ra1, wa;
      logic [31:0]       rd0, rd1;
      logic              we, is_load, is_md;
      logic [CTRL_W-1:0] ctrl;
   } instr_t;

   instr_t m_ex;
   bit     m_md_issued;
   int     m_cnt;
   int     n_cmp = 0;
   int     n_bad = 0;
   int     base;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ex        = '{default: '0};
      m_md_issued = 1'b0;
      m_cnt       = 0;
   endtask

   task automatic decide(output bit hold, output bit flush, output bit lu);
      bit reads_dest;
      hold = m_ex.valid && m_ex.is_md && !(m_md_issued && bus.md_done);
      reads_dest = (m_ex.wa == bus.id_ra0) || (m_ex.wa == bus.id_ra1);
      lu = bus.id_valid && m_ex.valid && m_ex.is_load && m_ex.we && (m_ex.wa != 0) && reads_dest;
      flush = m_ex.valid && bus.ex_br_taken && !hold;
   endtask

   task automatic at_neg();
      bit hold, flush, lu, stall;
      @(negedge clk);
      decide(hold, flush, lu);
      stall = hold || (lu && !flush);
      chk("ex_valid", 32'(bus.ex_valid), 32'(m_ex.valid));
      chk("rf_we_ex", 32'(bus.rf_we_ex), 32'(m_ex.valid & m_ex.we));
      chk("md_start", 32'(bus.md_start), 32'(m_ex.valid & m_ex.is_md & !m_md_issued));
      chk("stall_pc", 32'(bus.stall_pc), 32'(stall));
      chk("stall_if_id", 32'(bus.stall_if_id), 32'(stall));
      chk("flush_if_id", 32'(bus.flush_if_id), 32'(flush));
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
      if (m_ex.valid) begin
         chk("rf_ra0_ex", 32'(bus.rf_ra0_ex), 32'(m_ex.ra0));
         chk("rf_ra1_ex", 32'(bus.rf_ra1_ex), 32'(m_ex.ra1));
         chk("rf_rd0_ex", bus.rf_rd0_ex, m_ex.rd0);
         chk("rf_rd1_ex", bus.rf_rd1_ex, m_ex.rd1);
         chk("rf_wa_ex", 32'(bus.rf_wa_ex), 32'(m_ex.wa));
         chk("ctrl_ex", 32'(bus.ctrl_ex), 32'(m_ex.ctrl));
      end
   endtask

   task automatic at_pos();
      bit hold, flush, lu;
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else begin
         decide(hold, flush, lu);
         if (hold || (lu && !flush)) m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
         if (!m_md_issued && m_ex.valid && m_ex.is_md) m_md_issued = 1'b1;
         else if (m_md_issued && bus.md_done) m_md_issued = 1'b0;
         if (!hold) begin
            if (flush || lu) begin
               m_ex.valid = 1'b0; m_ex.we = 1'b0; m_ex.is_load = 1'b0; m_ex.is_md = 1'b0;
            end else begin
               m_ex = '{valid: bus.id_valid, ra0: bus.id_ra0, ra1: bus.id_ra1, wa: bus.id_wa,
                        rd0: bus.id_rd0, rd1: bus.id_rd1, we: bus.id_we, is_load: bus.id_is_load,
                        is_md: bus.id_is_md, ctrl: bus.id_ctrl};
            end
         end
      end
   endtask

   task automatic cyc();
      at_neg();
      at_pos();
   endtask

   task automatic drive(input logic v, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] w, input logic we, input logic ld,
                        input logic md, input logic br, input logic dn);
      bus.id_valid    = v;
      bus.id_ra0      = a0;
      bus.id_ra1      = a1;
      bus.id_wa       = w;
      bus.id_we       = we;
      bus.id_is_load  = ld;
      bus.id_is_md    = md;
      bus.ex_br_taken = br;
      bus.md_done     = dn;
      bus.id_rd0      = $urandom();
      bus.id_rd1      = $urandom();
      bus.id_ctrl     = CTRL_W'($urandom());
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      model_reset();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      cyc();
      rst = 1'b0;

      // lw x5 followed by add x6,x5,x1: one bubble then add enters EX
      drive(1, 5'd1, 5'd0, 5'd5, 1, 1, 0, 0, 0);
      cyc();
      drive(1, 5'd5, 5'd1, 5'd6, 1, 0, 0, 0, 0);
      at_neg();
      chk("t1_stall_pc", 32'(bus.stall_pc), 32'd1);
      at_pos();
      at_neg();
      chk("t1_bubble", 32'(bus.ex_valid), 32'd0);
      at_pos();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      at_neg();
      chk("t1_add_ra0", 32'(bus.rf_ra0_ex), 32'd5);
      at_pos();

      // lw x0 then reader of x0: no stall
      drive(1, 5'd2, 5'd3, 5'd0, 1, 1, 0, 0, 0);
      cyc();
      drive(1, 5'd0, 5'd0, 5'd7, 1, 0, 0, 0, 0);
      at_neg();
      chk("t2_no_stall", 32'(bus.stall_pc), 32'd0);
      at_pos();

      // taken branch beats load-use
      drive(1, 5'd1, 5'd1, 5'd5, 1, 1, 0, 0, 0);
      cyc();
      drive(1, 5'd5, 5'd0, 5'd8, 1, 0, 0, 1, 0);
      at_neg();
      chk("t3_flush", 32'(bus.flush_if_id), 32'd1);
      chk("t3_stall_pc", 32'(bus.stall_pc), 32'd0);
      at_pos();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      at_neg();
      chk("t3_bubble", 32'(bus.ex_valid), 32'd0);
      at_pos();

      // div occupies EX until md_done, five stall cycles in total
      drive(1, 5'd2, 5'd3, 5'd4, 1, 0, 1, 0, 0);
      cyc();
      base = m_cnt;
      drive(1, 5'd1, 5'd2, 5'd9, 1, 0, 0, 0, 0);
      at_neg();
      chk("t4_md_start", 32'(bus.md_start), 32'd1);
      at_pos();
      for (int i = 0; i < 4; i++) cyc();
      bus.md_done = 1'b1;
      cyc();
      bus.md_done = 1'b0;
      at_neg();
      chk("t4_stall_cnt", 32'(bus.stall_cnt), 32'(base + 5));
      chk("t4_next_wa", 32'(bus.rf_wa_ex), 32'd9);
      at_pos();

      // reset during MD_WAIT, then a stray md_done
      drive(1, 5'd2, 5'd3, 5'd4, 1, 0, 1, 0, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      cyc();
      rst = 1'b1;
      model_reset();
      at_neg();
      chk("t5_ex_valid", 32'(bus.ex_valid), 32'd0);
      chk("t5_md_start", 32'(bus.md_start), 32'd0);
      chk("t5_stall_pc", 32'(bus.stall_pc), 32'd0);
      chk("t5_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      at_pos();
      rst = 1'b0;
      bus.md_done = 1'b1;
      cyc();
      bus.md_done = 1'b0;
      cyc();

      // long md stall saturates the counter
      drive(1, 5'd2, 5'd3, 5'd4, 1, 0, 1, 0, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++) cyc();
      at_neg();
      chk("t6_saturated", 32'(bus.stall_cnt), 32'(CNT_MAX));
      at_pos();
      bus.md_done = 1'b1;
      cyc();

      pulse_rst();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(499, 0) == 0) begin
            pulse_rst();
         end else begin
            drive(1'($urandom_range(3, 0) != 0), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                  5'($urandom_range(3, 0)), 1'($urandom_range(3, 0) != 0), 1'($urandom_range(2, 0) == 0),
                  1'($urandom_range(7, 0) == 0), 1'($urandom_range(7, 0) == 0),
                  m_md_issued ? 1'($urandom_range(3, 0) == 0) : 1'($urandom_range(15, 0) == 0));
            cyc();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
